// File: rtl/cursor_pkg.sv
// ---------------------------------------------------------------------------
// cursor_pkg
// Definitions shared by both ends of the tilt-cursor UART link.
//   - Single-byte cursor command codes. The transmit-side top uses the same
//     constants.
//   - Receive FSM state encoding.
//   - Helper that computes the 16x-oversample clock divisor.
// No ports (package).
// ---------------------------------------------------------------------------
package cursor_pkg;

    localparam logic [7:0] CMD_HOME   = 8'h63;
    localparam logic [7:0] CMD_TOP    = 8'h00;
    localparam logic [7:0] CMD_BOTTOM = 8'h01;
    localparam logic [7:0] CMD_LEFT   = 8'h02;
    localparam logic [7:0] CMD_RIGHT  = 8'h03;
    localparam logic [7:0] CMD_IDLE   = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Clocks per 16x-oversample tick. The division truncates and is clamped
    // to at least 1, so that very slow clocks still give a legal counter.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        int unsigned d;
        d = clk_freq / (baud * 16);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_cursor_rx_if.sv
// ---------------------------------------------------------------------------
// uart_cursor_rx_if
// Bundles the serial input and the decoded outputs of the cursor receiver.
//   rx          serial line, idle high
//   byte_data   last correctly framed byte
//   byte_valid  one-cycle pulse when byte_data updates
//   frame_err   one-cycle pulse on a bad stop bit
//   bad_cmd     one-cycle pulse for an undefined command byte
//   cur_x/cur_y cursor position
// Modports:
//   master : drives rx and observes the results (line driver / bench side)
//   slave  : the receiver itself
// ---------------------------------------------------------------------------
interface uart_cursor_rx_if #(
    parameter int X_MAX = 15,
    parameter int Y_MAX = 15
);
    localparam int XW = $clog2(X_MAX + 1);
    localparam int YW = $clog2(Y_MAX + 1);

    logic          rx;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          frame_err;
    logic          bad_cmd;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;

    modport master (
        output rx,
        input  byte_data, byte_valid, frame_err, bad_cmd, cur_x, cur_y
    );

    modport slave (
        input  rx,
        output byte_data, byte_valid, frame_err, bad_cmd, cur_x, cur_y
    );

endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 byte receiver with a 16x-oversampled tick.
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         raw serial input, asynchronous to clk, idle high
//   byte_data  last correctly framed byte; holds until the next good byte
//   byte_valid one-cycle pulse when byte_data updates
//   frame_err  one-cycle pulse when the stop bit is sampled low
// A two-flop synchroniser feeds everything. The start bit is confirmed half
// a bit in. Data and stop bits are then sampled every 16 ticks. A low stop
// bit parks the FSM in WAIT_HIGH until the line returns high, so a break is
// not decoded as a run of zero bytes.
// ---------------------------------------------------------------------------
module uart_rx
    import cursor_pkg::*;
#(
    parameter int unsigned DIV = 651
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int unsigned   DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    // Synchroniser: both stages reset to the idle level.
    logic rx_meta_reg;
    logic rxs_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rxs_reg     <= rx_meta_reg;
        end
    end

    rx_state_t   state_reg, state_next;
    logic [DW-1:0] div_reg;
    logic [3:0]  tick_cnt_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;
    logic [7:0]  byte_data_reg;
    logic        byte_valid_reg;
    logic        frame_err_reg;

    logic tick;
    logic start_entry;
    logic sample_en;

    assign tick        = (div_reg == DIV_LAST);
    // Dividing the tick from the falling edge keeps the sample points centred.
    assign start_entry = (state_reg == IDLE) && !rxs_reg;

    always_comb begin
        state_next = state_reg;
        sample_en  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (!rxs_reg) state_next = START;
            end
            START: begin
                if (tick && tick_cnt_reg == 4'd7) begin
                    sample_en  = 1'b1;
                    state_next = rxs_reg ? IDLE : DATA;  // high again: glitch
                end
            end
            DATA: begin
                if (tick && tick_cnt_reg == 4'd15) begin
                    sample_en = 1'b1;
                    if (bit_cnt_reg == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (tick && tick_cnt_reg == 4'd15) begin
                    sample_en  = 1'b1;
                    state_next = rxs_reg ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rxs_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg        <= '0;
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            byte_data_reg  <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;

            if (start_entry || tick) div_reg <= '0;
            else                     div_reg <= div_reg + DW'(1);

            if (start_entry) begin
                tick_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
            end else if (sample_en) begin
                tick_cnt_reg <= '0;
            end else if (tick) begin
                tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end

            if (sample_en && state_reg == DATA) begin
                shift_reg   <= {rxs_reg, shift_reg[7:1]};  // LSB first
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end

            if (sample_en && state_reg == STOP) begin
                if (rxs_reg) begin
                    byte_data_reg  <= shift_reg;
                    byte_valid_reg <= 1'b1;
                end else begin
                    frame_err_reg  <= 1'b1;
                end
            end
        end
    end

    assign byte_data  = byte_data_reg;
    assign byte_valid = byte_valid_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: rtl/uart_cursor_rx.sv
// ---------------------------------------------------------------------------
// uart_cursor_rx
// Display-side end of the tilt-cursor link. Receives 8N1 bytes (uart_rx)
// and decodes the single-byte command stream into a 2-D cursor position.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  uart_cursor_rx_if.slave: rx in; byte_data, byte_valid, frame_err,
//        bad_cmd, cur_x, cur_y out
// Build option:
//   CURSOR_WRAP_EN  defined: cursor movement wraps around at the edges.
//                   undefined: movement saturates at 0 and X_MAX/Y_MAX.
// The cursor and bad_cmd update on the cycle after byte_valid.
// ---------------------------------------------------------------------------
module uart_cursor_rx
    import cursor_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int          X_MAX    = 15,
    parameter int          Y_MAX    = 15
) (
    input  logic            clk,
    input  logic            rst,
    uart_cursor_rx_if.slave bus
);
    localparam int unsigned   DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int            XW    = $clog2(X_MAX + 1);
    localparam int            YW    = $clog2(Y_MAX + 1);
    localparam logic [XW-1:0] X_LIM = XW'(X_MAX);
    localparam logic [YW-1:0] Y_LIM = YW'(Y_MAX);

    logic [7:0] byte_data_w;
    logic       byte_valid_w;
    logic       frame_err_w;

    uart_rx #(.DIV(DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (bus.rx),
        .byte_data  (byte_data_w),
        .byte_valid (byte_valid_w),
        .frame_err  (frame_err_w)
    );

    logic [XW-1:0] cur_x_reg, cur_x_next;
    logic [YW-1:0] cur_y_reg, cur_y_next;
    logic          bad_cmd_reg, bad_cmd_next;

    logic [XW-1:0] x_dec, x_inc;
    logic [YW-1:0] y_dec, y_inc;

`ifdef CURSOR_WRAP_EN
    assign x_dec = (cur_x_reg == '0)    ? X_LIM : cur_x_reg - XW'(1);
    assign x_inc = (cur_x_reg >= X_LIM) ? '0    : cur_x_reg + XW'(1);
    assign y_dec = (cur_y_reg == '0)    ? Y_LIM : cur_y_reg - YW'(1);
    assign y_inc = (cur_y_reg >= Y_LIM) ? '0    : cur_y_reg + YW'(1);
`else
    assign x_dec = (cur_x_reg == '0)    ? '0    : cur_x_reg - XW'(1);
    assign x_inc = (cur_x_reg >= X_LIM) ? X_LIM : cur_x_reg + XW'(1);
    assign y_dec = (cur_y_reg == '0)    ? '0    : cur_y_reg - YW'(1);
    assign y_inc = (cur_y_reg >= Y_LIM) ? Y_LIM : cur_y_reg + YW'(1);
`endif

    always_comb begin
        cur_x_next   = cur_x_reg;
        cur_y_next   = cur_y_reg;
        bad_cmd_next = 1'b0;
        if (byte_valid_w) begin
            case (byte_data_w)
                CMD_HOME: begin
                    cur_x_next = '0;
                    cur_y_next = '0;
                end
                CMD_TOP:    cur_y_next = y_dec;
                CMD_BOTTOM: cur_y_next = y_inc;
                CMD_LEFT:   cur_x_next = x_dec;
                CMD_RIGHT:  cur_x_next = x_inc;
                CMD_IDLE:   ;
                default:    bad_cmd_next = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x_reg   <= '0;
            cur_y_reg   <= '0;
            bad_cmd_reg <= 1'b0;
        end else begin
            cur_x_reg   <= cur_x_next;
            cur_y_reg   <= cur_y_next;
            bad_cmd_reg <= bad_cmd_next;
        end
    end

    assign bus.byte_data  = byte_data_w;
    assign bus.byte_valid = byte_valid_w;
    assign bus.frame_err  = frame_err_w;
    assign bus.bad_cmd    = bad_cmd_reg;
    assign bus.cur_x      = cur_x_reg;
    assign bus.cur_y      = cur_y_reg;

endmodule
